// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings, scoreboard entry layout and the readiness/forwarding
// helpers used by the hazard scheduler.
package hazard_ctrl_pkg;

  localparam logic [1:0] STAGE_DECODE  = 2'd0;
  localparam logic [1:0] STAGE_EXECUTE = 2'd1;
  localparam logic [1:0] STAGE_MEM     = 2'd2;
  localparam logic [1:0] STAGE_MAX     = 2'd3;

  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_E   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;
  localparam logic [1:0] FWD_W   = 2'd3;

  localparam int MD_CNT_LEN = 4;

  typedef struct packed {
    logic [4:0] waddr;
    logic [1:0] wstage;
    logic [4:0] raddr0;
    logic [4:0] raddr1;
    logic       md_start;
    logic       md_div;
  } sb_entry_t;

  function automatic logic entry_hit(sb_entry_t ent, logic [4:0] addr);
    return (ent.waddr != 5'd0) && (ent.waddr == addr);
  endfunction

  function automatic logic entry_ready(sb_entry_t ent, logic [1:0] slot);
    return (ent.waddr != 5'd0) && (ent.wstage < slot);
  endfunction

  // Cycles until the entry's result exists, seen from pipeline slot `slot`.
  function automatic logic [1:0] entry_tnew(sb_entry_t ent, logic [1:0] slot);
    logic [2:0] avail;
    avail = {1'b0, ent.wstage} + 3'd1;
    if (avail > {1'b0, slot}) return 2'(avail - {1'b0, slot});
    return 2'd0;
  endfunction

  // Only the youngest writer of `addr` decides whether the reader must wait.
  function automatic logic port_stall(sb_entry_t e, sb_entry_t m, sb_entry_t w,
                                      logic [4:0] addr, logic [1:0] rstage);
    logic [1:0] tnew;
    tnew = 2'd0;
    if (entry_hit(e, addr))      tnew = entry_tnew(e, STAGE_EXECUTE);
    else if (entry_hit(m, addr)) tnew = entry_tnew(m, STAGE_MEM);
    else if (entry_hit(w, addr)) tnew = entry_tnew(w, STAGE_MAX);
    return (rstage != STAGE_MAX) && (tnew > rstage);
  endfunction

  // A younger writer that is not ready yet shadows older ready ones.
  function automatic logic [1:0] fwd_sel(sb_entry_t e, sb_entry_t m, sb_entry_t w,
                                         logic [4:0] addr);
    if (entry_hit(e, addr)) return entry_ready(e, STAGE_EXECUTE) ? FWD_E : FWD_GRF;
    if (entry_hit(m, addr)) return entry_ready(m, STAGE_MEM) ? FWD_M : FWD_GRF;
    if (entry_hit(w, addr)) return entry_ready(w, STAGE_MAX) ? FWD_W : FWD_GRF;
    return FWD_GRF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_counter.sv
// Mult/div busy countdown: loads the operation latency when an md op sits in
// E and counts down to zero; busy while nonzero.
module md_busy_counter
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic div_i,
  output logic busy_o
);

  logic [MD_CNT_LEN-1:0] cnt_q, cnt_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = div_i ? MD_CNT_LEN'(DIV_CYCLES) : MD_CNT_LEN'(MULT_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - MD_CNT_LEN'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline scoreboard for the 5-stage core: tracks writers in E/M/W, raises
// the global stall and drives the operand forwarding selects.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_read_addr0,
  input  logic [4:0] d_read_addr1,
  input  logic [1:0] d_read_stage0,
  input  logic [1:0] d_read_stage1,
  input  logic [4:0] d_write_addr,
  input  logic [1:0] d_write_stage,
  input  logic       d_md_start,
  input  logic       d_md_div,
  input  logic       d_md_use,
  output logic       stall,
  output logic [1:0] fwd_d0,
  output logic [1:0] fwd_d1,
  output logic [1:0] fwd_e0,
  output logic [1:0] fwd_e1,
  output logic [1:0] fwd_m1,
  output logic       md_busy
);

  sb_entry_t e_q, m_q, w_q;
  sb_entry_t e_d, m_d, w_d;
  sb_entry_t d_entry;
  logic      data_stall, md_stall;

  always_comb begin
    d_entry = '{waddr:    d_write_addr,
                wstage:   d_write_stage,
                raddr0:   d_read_addr0,
                raddr1:   d_read_addr1,
                md_start: d_md_start,
                md_div:   d_md_div};

    data_stall = port_stall(e_q, m_q, w_q, d_read_addr0, d_read_stage0)
               | port_stall(e_q, m_q, w_q, d_read_addr1, d_read_stage1);
    md_stall   = d_md_use && (md_busy || e_q.md_start);
    stall      = data_stall || md_stall;

    // A stall freezes D, so E receives a bubble while older stages drain.
    e_d = stall ? sb_entry_t'('0) : d_entry;
    m_d = e_q;
    w_d = m_q;

    fwd_d0 = fwd_sel(e_q, m_q, w_q, d_read_addr0);
    fwd_d1 = fwd_sel(e_q, m_q, w_q, d_read_addr1);
    fwd_e0 = fwd_sel(sb_entry_t'('0), m_q, w_q, e_q.raddr0);
    fwd_e1 = fwd_sel(sb_entry_t'('0), m_q, w_q, e_q.raddr1);
    fwd_m1 = fwd_sel(sb_entry_t'('0), sb_entry_t'('0), w_q, m_q.raddr1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_counter (
    .clk    (clk),
    .reset  (reset),
    .load_i (e_q.md_start),
    .div_i  (e_q.md_div),
    .busy_o (md_busy)
  );

  // Entry fields that older stages carry along but never consult.
  logic unused_fields;
  assign unused_fields = ^{m_q.raddr0, m_q.md_start, m_q.md_div,
                           w_q.raddr0, w_q.raddr1, w_q.md_start, w_q.md_div};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: scripted instruction pairs with
// hand-derived expectations queued per cycle and compared after settling.
module tb_hazard_ctrl;

  localparam logic [1:0] S_D = 2'd0, S_E = 2'd1, S_M = 2'd2, S_NONE = 2'd3;
  localparam int F_GRF = 0, F_E = 1, F_M = 2, F_W = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_read_addr0, d_read_addr1, d_write_addr;
  logic [1:0] d_read_stage0, d_read_stage1, d_write_stage;
  logic       d_md_start, d_md_div, d_md_use;
  logic       stall, md_busy;
  logic [1:0] fwd_d0, fwd_d1, fwd_e0, fwd_e1, fwd_m1;

  hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk           (clk),
    .reset         (reset),
    .d_read_addr0  (d_read_addr0),
    .d_read_addr1  (d_read_addr1),
    .d_read_stage0 (d_read_stage0),
    .d_read_stage1 (d_read_stage1),
    .d_write_addr  (d_write_addr),
    .d_write_stage (d_write_stage),
    .d_md_start    (d_md_start),
    .d_md_div      (d_md_div),
    .d_md_use      (d_md_use),
    .stall         (stall),
    .fwd_d0        (fwd_d0),
    .fwd_d1        (fwd_d1),
    .fwd_e0        (fwd_e0),
    .fwd_e1        (fwd_e1),
    .fwd_m1        (fwd_m1),
    .md_busy       (md_busy)
  );

  always #5 clk = ~clk;

  typedef enum int {O_STALL, O_FD0, O_FD1, O_FE0, O_FE1, O_FM1, O_BUSY} out_e;
  typedef struct {
    string tag;
    out_e  sel;
    int    val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int observe(out_e sel);
    case (sel)
      O_STALL: return int'(stall);
      O_FD0:   return int'(fwd_d0);
      O_FD1:   return int'(fwd_d1);
      O_FE0:   return int'(fwd_e0);
      O_FE1:   return int'(fwd_e1);
      O_FM1:   return int'(fwd_m1);
      default: return int'(md_busy);
    endcase
  endfunction

  task automatic expect_out(input string tag, input out_e sel, input int val);
    exp_t ent;
    ent.tag = tag;
    ent.sel = sel;
    ent.val = val;
    sb_q.push_back(ent);
  endtask

  task automatic check_pending();
    exp_t ent;
    #1;
    while (sb_q.size() > 0) begin
      ent = sb_q.pop_front();
      check(ent.tag, observe(ent.sel), ent.val);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [4:0] ra0, input logic [1:0] rs0,
                       input logic [4:0] ra1, input logic [1:0] rs1,
                       input logic [4:0] wa, input logic [1:0] ws,
                       input logic mds, input logic mdd, input logic mdu);
    d_read_addr0  = ra0;
    d_read_stage0 = rs0;
    d_read_addr1  = ra1;
    d_read_stage1 = rs1;
    d_write_addr  = wa;
    d_write_stage = ws;
    d_md_start    = mds;
    d_md_div      = mdd;
    d_md_use      = mdu;
  endtask

  task automatic set_nop();
    set_d(5'd0, S_NONE, 5'd0, S_NONE, 5'd0, S_D, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    set_nop();
    cyc();
    expect_out("rst_stall", O_STALL, 0);
    expect_out("rst_fd0",   O_FD0,   F_GRF);
    expect_out("rst_fd1",   O_FD1,   F_GRF);
    expect_out("rst_fe0",   O_FE0,   F_GRF);
    expect_out("rst_fe1",   O_FE1,   F_GRF);
    expect_out("rst_fm1",   O_FM1,   F_GRF);
    expect_out("rst_busy",  O_BUSY,  0);
    check_pending();
    reset = 1'b0;

    // lw $1 ; addu reading $1 in E
    cyc(); set_d(5'd0, S_NONE, 5'd0, S_NONE, 5'd1, S_M, 1'b0, 1'b0, 1'b0);
    expect_out("lw_issue_stall", O_STALL, 0);
    check_pending();
    cyc(); set_d(5'd1, S_E, 5'd0, S_NONE, 5'd4, S_E, 1'b0, 1'b0, 1'b0);
    expect_out("lwuse_stall1", O_STALL, 1);
    expect_out("lwuse_fd0_e",  O_FD0, F_GRF);
    check_pending();
    cyc();
    expect_out("lwuse_stall2", O_STALL, 0);
    expect_out("lwuse_fd0_m",  O_FD0, F_GRF);
    check_pending();
    cyc(); set_nop();
    expect_out("lwuse_fe0_w",  O_FE0, F_W);
    expect_out("lwuse_free",   O_STALL, 0);
    check_pending();

    // addu $2 ; beq reading $2 in D
    cyc(); set_d(5'd0, S_NONE, 5'd0, S_NONE, 5'd2, S_E, 1'b0, 1'b0, 1'b0);
    check_pending();
    cyc(); set_d(5'd2, S_D, 5'd0, S_NONE, 5'd0, S_D, 1'b0, 1'b0, 1'b0);
    expect_out("beq_stall1", O_STALL, 1);
    expect_out("beq_fd0_e",  O_FD0, F_GRF);
    check_pending();
    cyc();
    expect_out("beq_stall2", O_STALL, 0);
    expect_out("beq_fd0_m",  O_FD0, F_M);
    check_pending();
    // addu $2 ; nop ; beq $2
    cyc(); set_d(5'd0, S_NONE, 5'd0, S_NONE, 5'd2, S_E, 1'b0, 1'b0, 1'b0);
    check_pending();
    cyc(); set_nop();
    check_pending();
    cyc(); set_d(5'd2, S_D, 5'd0, S_NONE, 5'd0, S_D, 1'b0, 1'b0, 1'b0);
    expect_out("beqnop_stall", O_STALL, 0);
    expect_out("beqnop_fd0",   O_FD0, F_M);
    check_pending();

    // jal ; jr $31
    cyc(); set_d(5'd0, S_NONE, 5'd0, S_NONE, 5'd31, S_D, 1'b0, 1'b0, 1'b0);
    check_pending();
    cyc(); set_d(5'd31, S_D, 5'd0, S_NONE, 5'd0, S_D, 1'b0, 1'b0, 1'b0);
    expect_out("jr_stall", O_STALL, 0);
    expect_out("jr_fd0",   O_FD0, F_E);
    check_pending();

    // addu $7 ; lw $7 ; reader of $7 in E: the younger lw must win
    cyc(); set_d(5'd0, S_NONE, 5'd0, S_NONE, 5'd7, S_E, 1'b0, 1'b0, 1'b0);
    check_pending();
    cyc(); set_d(5'd0, S_NONE, 5'd0, S_NONE, 5'd7, S_M, 1'b0, 1'b0, 1'b0);
    check_pending();
    cyc(); set_d(5'd7, S_E, 5'd0, S_NONE, 5'd0, S_D, 1'b0, 1'b0, 1'b0);
    expect_out("prio_stall1", O_STALL, 1);
    check_pending();
    cyc();
    expect_out("prio_stall2", O_STALL, 0);
    expect_out("prio_fd0",    O_FD0, F_GRF);
    check_pending();
    cyc(); set_nop();
    expect_out("prio_fe0", O_FE0, F_W);
    check_pending();

    // lw $3 ; sw with rt $3 needed in M
    cyc(); set_d(5'd0, S_NONE, 5'd0, S_NONE, 5'd3, S_M, 1'b0, 1'b0, 1'b0);
    check_pending();
    cyc(); set_d(5'd0, S_E, 5'd3, S_M, 5'd0, S_D, 1'b0, 1'b0, 1'b0);
    expect_out("sw_stall", O_STALL, 0);
    expect_out("sw_fd1",   O_FD1, F_GRF);
    check_pending();
    cyc(); set_nop();
    expect_out("sw_fe1", O_FE1, F_GRF);
    check_pending();
    cyc();
    expect_out("sw_fm1", O_FM1, F_W);
    check_pending();

    // write to $0 ; reader of $0
    cyc(); set_d(5'd0, S_NONE, 5'd0, S_NONE, 5'd0, S_M, 1'b0, 1'b0, 1'b0);
    check_pending();
    cyc(); set_d(5'd0, S_D, 5'd0, S_E, 5'd0, S_D, 1'b0, 1'b0, 1'b0);
    expect_out("zero_stall", O_STALL, 0);
    expect_out("zero_fd0",   O_FD0, F_GRF);
    expect_out("zero_fd1",   O_FD1, F_GRF);
    check_pending();
    cyc(); set_nop();
    expect_out("zero_fe0", O_FE0, F_GRF);
    expect_out("zero_fe1", O_FE1, F_GRF);
    check_pending();

    // div ; mfhi : stall 1 + DIV_CYCLES cycles
    cyc(); set_d(5'd4, S_E, 5'd5, S_E, 5'd0, S_D, 1'b1, 1'b1, 1'b1);
    expect_out("div_issue_stall", O_STALL, 0);
    expect_out("div_issue_busy",  O_BUSY, 0);
    check_pending();
    cyc(); set_d(5'd0, S_NONE, 5'd0, S_NONE, 5'd6, S_E, 1'b0, 1'b0, 1'b1);
    expect_out("div_e_stall", O_STALL, 1);
    expect_out("div_e_busy",  O_BUSY, 0);
    check_pending();
    for (int i = 1; i <= 10; i++) begin
      cyc();
      expect_out($sformatf("div_cnt%0d_stall", i), O_STALL, 1);
      expect_out($sformatf("div_cnt%0d_busy", i),  O_BUSY, 1);
      check_pending();
    end
    cyc();
    expect_out("div_done_stall", O_STALL, 0);
    expect_out("div_done_busy",  O_BUSY, 0);
    check_pending();

    // div ; mfhi ; reset at count 4 discards the operation
    cyc(); set_d(5'd0, S_NONE, 5'd0, S_NONE, 5'd0, S_D, 1'b1, 1'b1, 1'b1);
    check_pending();
    cyc(); set_d(5'd0, S_NONE, 5'd0, S_NONE, 5'd6, S_E, 1'b0, 1'b0, 1'b1);
    check_pending();
    for (int i = 1; i <= 7; i++) cyc();
    expect_out("rstmd_pre_busy", O_BUSY, 1);
    check_pending();
    reset = 1'b1;
    cyc();
    expect_out("rstmd_busy",  O_BUSY, 0);
    expect_out("rstmd_stall", O_STALL, 0);
    check_pending();
    reset = 1'b0;

    // mult: MULT_CYCLES busy cycles, md user stalled while busy
    cyc(); set_d(5'd0, S_NONE, 5'd0, S_NONE, 5'd0, S_D, 1'b1, 1'b0, 1'b1);
    expect_out("mult_issue_stall", O_STALL, 0);
    check_pending();
    cyc(); set_nop();
    expect_out("mult_e_busy", O_BUSY, 0);
    check_pending();
    for (int i = 1; i <= 5; i++) begin
      cyc();
      if (i == 3) set_d(5'd0, S_NONE, 5'd0, S_NONE, 5'd0, S_D, 1'b0, 1'b0, 1'b1);
      else        set_nop();
      expect_out($sformatf("mult_cnt%0d_busy", i),  O_BUSY, 1);
      expect_out($sformatf("mult_cnt%0d_stall", i), O_STALL, (i == 3) ? 1 : 0);
      check_pending();
    end
    cyc();
    expect_out("mult_done_busy", O_BUSY, 0);
    check_pending();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline scoreboard and hazard scheduler for the 5-stage MIPS core (F/D/E/M/W).
- Consumes the decode stage's per-operand read-stage and write-stage tags and tracks every in-flight writer through E/M/W.
- Drives the global stall (freeze F/D, bubble into E) and the forwarding-mux selects for D, E and M operands.
- Also owns the mult/div busy countdown that gates HI/LO users.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu enters E
- DIV_CYCLES, 10, busy cycles after a div/divu enters E

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- d_read_addr0  in  5  D-stage rs address
- d_read_addr1  in  5  D-stage rt address
- d_read_stage0  in  2  stage at which rs is first needed (Tuse)
- d_read_stage1  in  2  stage at which rt is first needed
- d_write_addr  in  5  D-stage destination; 0 = no write
- d_write_stage  in  2  stage after which result exists
- d_md_start  in  1  D instr is mult/multu/div/divu
- d_md_div  in  1  qualifies d_md_start: 1 = divide
- d_md_use  in  1  D instr reads/writes HI/LO or starts md
- stall  out  1  freeze PC and F/D reg; insert bubble into D/E reg
- fwd_d0, fwd_d1  out  2  forward select, D operands
- fwd_e0, fwd_e1  out  2  forward select, E operands
- fwd_m1  out  2  forward select, M rt (store data)
- md_busy  out  1  md counter nonzero

Behaviour:
- Stage encoding in def.v: STAGE_DECODE=0, STAGE_EXECUTE=1, STAGE_MEM=2, STAGE_MAX=3. STAGE_MAX as a read stage means "not read".
- Forward select encoding: FWD_GRF=0, FWD_E=1, FWD_M=2, FWD_W=3.
- Scoreboard holds one entry each for E, M, W: {waddr[4:0], wstage[1:0], raddr0, raddr1, md_start, md_div}. Bubble = all-zero entry.
- Posedge, no stall: D inputs→E, E→M, M→W.
- Posedge, stall: bubble→E; E→M and M→W still advance.
- Readiness: an entry at stage index X (E=1, M=2, W=3) holds a valid result iff waddr≠0 and wstage<X.
  - Tnew = wstage+1−X, clamped at 0.
- Data stall: for read port p, stall if some entry has waddr==d_read_addr p, waddr≠0, d_read_stage p≠3, and Tnew > d_read_stage p.
  - Only the youngest matching entry counts; priority order is E, then M, then W.
- Forward select: youngest matching entry (priority E, M, W) that is ready. If the youngest match is not ready, output FWD_GRF; the stall covers that case.
  - E operands search M and W only.
  - M rt searches W only.
  - Address 0 never forwards.
- md counter:
  - Loads MULT_CYCLES or DIV_CYCLES on the posedge after which an md_start entry sits in E; that entry is in the scoreboard's E slot at the edge.
  - Otherwise decrements toward 0 each cycle.
  - md_busy = counter≠0.
- md stall: d_md_use && (md_busy || E entry md_start).
- stall = data stall OR md stall, purely combinational from current state and D inputs. No latency beyond that.
- Simultaneous load and decrement: load wins.
- A new md_start while busy cannot occur, because the md stall holds it in D.
- Reset: all entries bubble, counter 0. stall, md_busy and all fwd_* are 0 in the cycle after reset is sampled. Reset mid-countdown discards the operation.

Decomposition:
- def.v: STAGE_* (existing), FWD_GRF/FWD_E/FWD_M/FWD_W, MD_CNT_LEN (4).
- One sub-module, md_busy_counter: load / decrement / busy flag. Scoreboard and compare logic stay in hazard_ctrl.

Test Plan:
- lw $1 in D (write_stage 2), next cycle addu reading $1 at stage 1 → stall=1 for 1 cycle. Then fwd_e0=FWD_W once lw reaches W and addu is in E.
- addu $2 followed by beq reading $2 at stage 0 → stall=1 for 1 cycle, then fwd_d0=FWD_M. A nop separating them → no stall, fwd_d0=FWD_M.
- jal (write $31, stage 0) then jr $31 → no stall, fwd_d0=FWD_E.
- lw $3 then sw reading rt $3 at stage 2 → no stall, fwd_m1=FWD_W on the sw's M cycle.
- Write to $0 (d_write_addr=0) followed by a $0 reader → stall=0, all fwd=FWD_GRF.
- div followed immediately by mfhi (md_use) → stall held 1+DIV_CYCLES=11 cycles, md_busy drops after 10. Assert reset at count 4 → md_busy=0 next cycle, stall released.
